aec_job_arbiter: RTL and testbench

- Shares one AEC expression-calculator core between NUM_REQ requesters.
- Each requester streams one ASCII expression, terminated by '=' (0x3D), over a valid/ready handshake. The block buffers the whole expression, grants the core round-robin and replays the bytes to the core without gaps, one per cycle.
- It captures the core's finish/result/valid and returns a one-cycle tagged response to the owning requester.
- Sits between the request fabric and the AEC core instance.

---
 rtl/aec_arb_pkg.sv | 17 +
 rtl/aec_job_arbiter_rr_arbiter.sv | 33 +++
 rtl/aec_job_arbiter.sv | 175 +++++++++++++++++
 tb/tb_aec_job_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aec_arb_pkg.sv
// Shared types and ASCII constants for the AEC job arbiter.
package aec_arb_pkg;

   typedef enum logic [2:0] {IDLE, COLLECT, PLAY, WAIT, RESP} arb_state_t;

   typedef enum logic [1:0] {
      OK       = 2'd0,
      INVALID  = 2'd1,
      OVERFLOW = 2'd2,
      TIMEOUT  = 2'd3
   } rsp_status_t;

   localparam logic [7:0] EQ   = 8'h3D;
   localparam logic [7:0] LPAR = 8'h28;
   localparam logic [7:0] RPAR = 8'h29;

endpackage

// File: rtl/aec_job_arbiter_rr_arbiter.sv
// Round-robin grant: first set request at or after the pointer, wrapping.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   input  logic                       en,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

   localparam int unsigned IW = $clog2(NUM_REQ);

   always_comb begin
      logic [IW:0] j;
      logic        found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      j         = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         j = {1'b0, ptr} + (IW+1)'(i);
         if (j >= (IW+1)'(NUM_REQ))
            j = j - (IW+1)'(NUM_REQ);
         if (en && !found && req[j[IW-1:0]]) begin
            found                = 1'b1;
            grant[j[IW-1:0]]     = 1'b1;
            grant_idx            = j[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/aec_job_arbiter.sv
// Shares one AEC core between NUM_REQ requesters: buffer, round-robin replay, tagged response.
// Optional AEC_ARB_STATS_EN adds saturating OK / error / timeout response counters.
module aec_job_arbiter
   import aec_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned BUF_DEPTH = 64,
   parameter int unsigned MAX_WAIT  = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   rsp_valid,
   output logic [31:0]          rsp_result,
   output logic [1:0]           rsp_status,
   output logic                 aec_ready,
   output logic [7:0]           aec_ascii,
   input  logic                 aec_finish,
   input  logic [31:0]          aec_result,
   input  logic                 aec_valid
`ifdef AEC_ARB_STATS_EN
   ,
   output logic [15:0]          stat_ok,
   output logic [15:0]          stat_err,
   output logic [15:0]          stat_timeout
`endif
);

   localparam int unsigned IW = $clog2(NUM_REQ);
   localparam int unsigned WW = $clog2(BUF_DEPTH + 1);
   localparam int unsigned RW = $clog2(BUF_DEPTH);
   localparam int unsigned TW = $clog2(MAX_WAIT + 1);

   arb_state_t         state;
   logic [IW-1:0]      ptr, g_idx, arb_idx;
   logic [NUM_REQ-1:0] g_oh, arb_oh;
   logic [7:0]         buf_mem [BUF_DEPTH];
   logic [WW-1:0]      wr;
   logic [RW-1:0]      rd;
   logic               ovf;
   logic [TW-1:0]      wd;
   logic [7:0]         in_byte;
   logic               accept;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req       (req_valid),
      .ptr       (ptr),
      .en        (state == IDLE),
      .grant     (arb_oh),
      .grant_idx (arb_idx)
   );

   always_comb begin
      in_byte = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++)
         if (g_idx == IW'(i)) in_byte = req_data[8*i +: 8];
   end

   assign req_ready = (state == COLLECT) ? g_oh : '0;
   assign accept    = |(req_valid & req_ready);

   always_ff @(posedge clk) begin
      if (accept && wr < WW'(BUF_DEPTH))
         buf_mem[wr[RW-1:0]] <= in_byte;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         g_idx      <= '0;
         g_oh       <= '0;
         wr         <= '0;
         rd         <= '0;
         ovf        <= 1'b0;
         wd         <= '0;
         rsp_valid  <= '0;
         rsp_result <= '0;
         rsp_status <= OK;
         aec_ready  <= 1'b0;
         aec_ascii  <= EQ;
      end else begin
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  g_idx <= arb_idx;
                  g_oh  <= arb_oh;
                  state <= COLLECT;
               end
            end
            COLLECT: begin
               if (accept) begin
                  if (in_byte == EQ) begin
                     if (ovf) begin
                        rsp_valid  <= g_oh;
                        rsp_result <= '0;
                        rsp_status <= OVERFLOW;
                        state      <= RESP;
                     end else begin
                        // first replay byte is registered now; a lone '=' has not reached buf_mem yet
                        wr        <= wr + 1'b1;
                        aec_ready <= 1'b1;
                        aec_ascii <= (wr == '0) ? in_byte : buf_mem[0];
                        rd        <= RW'(1);
                        wd        <= '0;
                        state     <= PLAY;
                     end
                  end else if (!ovf) begin
                     wr <= wr + 1'b1;
                     if (wr == WW'(BUF_DEPTH - 1)) ovf <= 1'b1;
                  end
               end
            end
            PLAY, WAIT: begin
               aec_ready <= 1'b0;
               if (aec_finish) begin
                  rsp_valid  <= g_oh;
                  rsp_result <= aec_result;
                  rsp_status <= aec_valid ? OK : INVALID;
                  aec_ascii  <= EQ;
                  state      <= RESP;
               end else if (wd == TW'(MAX_WAIT - 1)) begin
                  rsp_valid  <= g_oh;
                  rsp_result <= '0;
                  rsp_status <= TIMEOUT;
                  aec_ascii  <= EQ;
                  state      <= RESP;
               end else begin
                  wd <= wd + 1'b1;
                  if (state == PLAY) begin
                     if (aec_ascii == EQ) begin
                        state <= WAIT;
                     end else begin
                        aec_ascii <= buf_mem[rd];
                        rd        <= rd + 1'b1;
                     end
                  end
               end
            end
            RESP: begin
               rsp_valid  <= '0;
               rsp_result <= '0;
               rsp_status <= OK;
               wr         <= '0;
               ovf        <= 1'b0;
               wd         <= '0;
               ptr        <= (g_idx == IW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef AEC_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_ok      <= '0;
         stat_err     <= '0;
         stat_timeout <= '0;
      end else if (state == RESP) begin
         case (rsp_status)
            OK:                if (stat_ok != '1)      stat_ok      <= stat_ok + 1'b1;
            INVALID, OVERFLOW: if (stat_err != '1)     stat_err     <= stat_err + 1'b1;
            default:           if (stat_timeout != '1) stat_timeout <= stat_timeout + 1'b1;
         endcase
      end
   end
`else
   // statistics counters not built
`endif

endmodule

// File: tb/tb_aec_job_arbiter.sv
// Directed table-driven bench for aec_job_arbiter with a scripted stub AEC core.
module tb_aec_job_arbiter;
   import aec_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [3:0]  rsp_valid;
   logic [31:0] rsp_result;
   logic [1:0]  rsp_status;
   logic        aec_ready;
   logic [7:0]  aec_ascii;
   logic        aec_finish;
   logic [31:0] aec_result;
   logic        aec_valid;

   aec_job_arbiter #(.NUM_REQ(4), .BUF_DEPTH(8), .MAX_WAIT(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_result (rsp_result),
      .rsp_status (rsp_status),
      .aec_ready  (aec_ready),
      .aec_ascii  (aec_ascii),
      .aec_finish (aec_finish),
      .aec_result (aec_result),
      .aec_valid  (aec_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int ncmp = 0;
   int nfail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // stub core knobs (written by the main sequence only)
   logic [31:0] core_res;
   logic        core_vld;
   int          early_idx;
   int          core_delay;
   bit          core_never;
   bit          use_map;
   int          fin_at;
   logic [31:0] res_map [256];

   // stub core state (written by the stub only)
   logic [7:0]  plog [16];
   int          nplay, nready, play0_cyc, fin_cyc, cnt;
   bit          playing, waiting;

   task fire();
      aec_finish = 1'b1;
      aec_result = use_map ? res_map[plog[0]] : core_res;
      aec_valid  = core_vld;
      fin_cyc    = cyc;
   endtask

   initial begin
      aec_finish = 1'b0; aec_result = '0; aec_valid = 1'b0;
      playing = 0; waiting = 0; nplay = 0; nready = 0; cnt = 0;
      play0_cyc = 0; fin_cyc = 0;
      forever begin
         @(posedge clk); #2;
         aec_finish = 1'b0;
         if (rst) begin
            playing = 0;
            waiting = 0;
         end else if (cyc == fin_at) begin
            aec_finish = 1'b1; aec_result = 32'hBAD; aec_valid = 1'b1;
         end else begin
            if (aec_ready) begin
               playing = 1; waiting = 0; nplay = 0; play0_cyc = cyc; nready++;
            end
            if (playing) begin
               if (nplay < 16) plog[nplay] = aec_ascii;
               nplay++;
               if (early_idx == nplay - 1) begin
                  fire();
                  playing = 0;
               end else if (aec_ascii == EQ) begin
                  playing = 0; waiting = 1; cnt = core_delay;
               end
            end else if (waiting && !core_never) begin
               if (cnt == 0) begin
                  fire();
                  waiting = 0;
               end else cnt--;
            end
         end
      end
   end

   // response monitor
   logic [3:0]  r_oh  [64];
   logic [31:0] r_res [64];
   logic [1:0]  r_st  [64];
   int          r_cyc [64];
   bit          r_asc [64];
   int          rsp_n = 0;
   int          onehot_bad = 0;

   always @(negedge clk) begin
      if (!rst && rsp_valid != '0 && rsp_n < 64) begin
         r_oh[rsp_n]  = rsp_valid;
         r_res[rsp_n] = rsp_result;
         r_st[rsp_n]  = rsp_status;
         r_cyc[rsp_n] = cyc;
         r_asc[rsp_n] = (aec_ascii == EQ) && !aec_ready;
         rsp_n++;
      end
      if (!$onehot0(req_ready)) onehot_bad++;
   end

   task automatic drive(input int r, input string s);
      for (int k = 0; k < s.len(); k++) begin
         int g = 0;
         req_valid[r]       = 1'b1;
         req_data[8*r +: 8] = s[k];
         @(negedge clk);
         while (!req_ready[r] && g < 300) begin
            @(negedge clk);
            g++;
         end
         if (g >= 300) chk($sformatf("drive_r%0d_byte%0d_accepted", r, k), 32'd0, 32'd1);
         @(posedge clk); #1;
      end
      req_valid[r] = 1'b0;
   endtask

   task automatic wait_rsp(input int target, input string tag);
      int g = 0;
      while (rsp_n < target && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk($sformatf("%s_arrived", tag), 32'(rsp_n >= target), 32'd1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req_ready"},  32'(req_ready),  32'd0);
      chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
      chk({tag, "_rsp_result"}, rsp_result,      32'd0);
      chk({tag, "_rsp_status"}, 32'(rsp_status), 32'd0);
      chk({tag, "_aec_ready"},  32'(aec_ready),  32'd0);
      chk({tag, "_aec_ascii"},  32'(aec_ascii),  32'h3D);
   endtask

   typedef struct {
      int          r;
      logic [31:0] res;
      bit          vld;
      int          early;
      int          dly;
      bit          never;
      logic [31:0] exp_res;
      logic [1:0]  exp_st;
   } vec_t;

   vec_t  vt [7];
   string vx [7];

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "bench time limit");
   end

   initial begin
      int base_n, base_rdy, explen;
      string s;

      vt[0] = '{0, 32'd7,    1'b1, -1, 2, 1'b0, 32'd7,    2'd0}; vx[0] = "3+4=";
      vt[1] = '{1, 32'd30,   1'b1, -1, 0, 1'b0, 32'd30,   2'd0}; vx[1] = "a*(2+1)=";
      vt[2] = '{3, 32'h55,   1'b0,  2, 0, 1'b0, 32'h55,   2'd1}; vx[2] = "3+)=";
      vt[3] = '{2, 32'h1234, 1'b1, -1, 1, 1'b0, 32'h1234, 2'd0}; vx[3] = "=";
      vt[4] = '{1, 32'd5,    1'b1, -1, 0, 1'b0, 32'd0,    2'd2}; vx[4] = "1+1+1+1+1=";
      vt[5] = '{0, 32'd7,    1'b1, -1, 0, 1'b1, 32'd0,    2'd3}; vx[5] = "9-2=";
      vt[6] = '{2, 32'd99,   1'b0, -1, 3, 1'b0, 32'd99,   2'd1}; vx[6] = "5/0=";

      for (int i = 0; i < 256; i++) res_map[i] = 32'hFFFF_FFFF;
      res_map[8'h31] = 32'd2;  // "1+1="
      res_map[8'h32] = 32'd4;  // "2*2="
      res_map[8'h34] = 32'd1;  // "4-3="
      res_map[8'h36] = 32'd3;  // "6/2="
      res_map[8'h38] = 32'd7;  // "8-1="

      core_res = '0; core_vld = 1'b1; early_idx = -1; core_delay = 0;
      core_never = 1'b0; use_map = 1'b0; fin_at = -1;
      rst = 1'b1; req_valid = '0; req_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset("por");
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         core_res = vt[i].res; core_vld = vt[i].vld; early_idx = vt[i].early;
         core_delay = vt[i].dly; core_never = vt[i].never;
         base_n = rsp_n; base_rdy = nready; s = vx[i];
         drive(vt[i].r, s);
         wait_rsp(base_n + 1, $sformatf("v%0d", i));
         repeat (3) @(negedge clk);
         chk($sformatf("v%0d_rsp_count", i),  32'(rsp_n - base_n), 32'd1);
         chk($sformatf("v%0d_rsp_owner", i),  32'(r_oh[base_n]), 32'(4'b1 << vt[i].r));
         chk($sformatf("v%0d_rsp_result", i), r_res[base_n], vt[i].exp_res);
         chk($sformatf("v%0d_rsp_status", i), 32'(r_st[base_n]), 32'(vt[i].exp_st));
         chk($sformatf("v%0d_idle_core_bus", i), 32'(r_asc[base_n]), 32'd1);
         chk($sformatf("v%0d_start_strobes", i), 32'(nready - base_rdy),
             (vt[i].exp_st == 2'd2) ? 32'd0 : 32'd1);
         if (vt[i].exp_st != 2'd2) begin
            explen = (vt[i].early >= 0) ? vt[i].early + 1 : s.len();
            chk($sformatf("v%0d_replay_len", i), 32'(nplay), 32'(explen));
            for (int k = 0; k < explen; k++)
               chk($sformatf("v%0d_replay_byte%0d", i, k), 32'(plog[k]), 32'(s[k]));
            if (vt[i].never)
               chk($sformatf("v%0d_timeout_latency", i), 32'(r_cyc[base_n] - play0_cyc), 32'd16);
            else
               chk($sformatf("v%0d_finish_to_rsp", i), 32'(r_cyc[base_n] - fin_cyc), 32'd1);
         end
      end

      // reset in the middle of a replay: no response, outputs back to reset values
      use_map = 1'b1; core_vld = 1'b1; early_idx = -1; core_delay = 1; core_never = 1'b1;
      base_n = rsp_n; base_rdy = nready;
      drive(2, "7*7=");
      begin
         int g = 0;
         while (nready == base_rdy && g < 50) begin
            @(negedge clk);
            g++;
         end
      end
      chk("rst_mid_play_started", 32'(nready - base_rdy), 32'd1);
      rst = 1'b1;
      #1;
      chk_reset("mid_rst");
      @(negedge clk); rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("mid_rst_no_response", 32'(rsp_n - base_n), 32'd0);

      // pointer restarts at requester 0 after reset
      core_never = 1'b0;
      base_n = rsp_n;
      fork
         drive(3, "8-1=");
         drive(0, "1+1=");
      join
      wait_rsp(base_n + 2, "post_rst");
      chk("post_rst_first_owner",  32'(r_oh[base_n]),      32'h1);
      chk("post_rst_first_res",    r_res[base_n],          32'd2);
      chk("post_rst_second_owner", 32'(r_oh[base_n + 1]),  32'h8);
      chk("post_rst_second_res",   r_res[base_n + 1],      32'd7);

      // finish strobe while idle is ignored
      base_n = rsp_n;
      fin_at = cyc + 2;
      repeat (6) @(negedge clk);
      chk("idle_finish_ignored", 32'(rsp_n - base_n), 32'd0);
      fin_at = -1;

      // contention: 0 and 2 together, then 0 and 3 arrive while 2 is pending
      base_n = rsp_n;
      fork
         drive(0, "1+1=");
         drive(2, "2*2=");
         begin
            wait_rsp(base_n + 1, "cont_first");
            fork
               drive(0, "6/2=");
               drive(3, "4-3=");
            join
         end
      join
      wait_rsp(base_n + 4, "cont_all");
      repeat (3) @(negedge clk);
      chk("cont_count",  32'(rsp_n - base_n), 32'd4);
      chk("cont0_owner", 32'(r_oh[base_n]),     32'h1);
      chk("cont0_res",   r_res[base_n],         32'd2);
      chk("cont1_owner", 32'(r_oh[base_n + 1]), 32'h4);
      chk("cont1_res",   r_res[base_n + 1],     32'd4);
      chk("cont2_owner", 32'(r_oh[base_n + 2]), 32'h8);
      chk("cont2_res",   r_res[base_n + 2],     32'd1);
      chk("cont3_owner", 32'(r_oh[base_n + 3]), 32'h1);
      chk("cont3_res",   r_res[base_n + 3],     32'd3);
      chk("cont_gap",    32'(r_cyc[base_n + 1] - r_cyc[base_n] > 1), 32'd1);

      chk("req_ready_onehot0_violations", 32'(onehot_bad), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
